// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg
//   Shared constants and types for the push-button conditioning slice.
//   - DEF_* : default timing at a 50 MHz board clock (10 ms debounce,
//             250 ms first auto-repeat, 100 ms repeat period).
//   - KEY_LEFT / KEY_RIGHT : key-bus bit positions that feed the game's
//             left/right controls.
//   - rep_state_e : per-key auto-repeat state.
//   - max_int : constant helper for sizing the repeat counter.
package key_conditioner_pkg;

  localparam int DEF_DB_CYCLES  = 500000;
  localparam int DEF_REP_DELAY  = 12500000;
  localparam int DEF_REP_PERIOD = 5000000;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_WAIT   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// key_channel
//   One key's conditioning path: 2-FF synchroniser, stability-counter
//   debounce and auto-repeat FSM. All outputs are registered.
//   Ports:
//     clk   in   board clock
//     reset in   asynchronous active-high reset
//     raw   in   key line, already polarity-corrected (1 = pressed)
//     db    out  debounced level
//     press out  one-cycle strobe on debounced 0->1
//     rel   out  one-cycle strobe on debounced 1->0
//     rep   out  one-cycle strobe on press and on every auto-repeat
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic press,
  output logic rel,
  output logic rep
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(max_int(REP_DELAY, REP_PERIOD) + 1);
  localparam bit REP_ON = (REP_DELAY > 0);

  // Terminal counts: the event fires on the cycle the counter already
  // holds N-1, so exactly N qualifying cycles elapse.
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_ON ? (REP_DELAY - 1) : 0);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] RCNT_ONE = RW'(1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rep_q, rep_d;
  rep_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // Next-state logic for debounce level, strobes and the repeat FSM.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rep_d   = 1'b0;
    state_d = state_q;
    rcnt_d  = rcnt_q;

    // Any sample agreeing with the current level restarts the count,
    // so only an unbroken run of DB_CYCLES differing samples flips it.
    if (s2_q == db_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == DB_LAST) begin
      db_d    = s2_q;
      cnt_d   = {CW{1'b0}};
      press_d = s2_q;
      rel_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Release wins over everything; a press strobe doubles as the first rep.
    if (rel_d) begin
      state_d = REP_IDLE;
      rcnt_d  = {RW{1'b0}};
    end else if (press_d) begin
      state_d = REP_WAIT;
      rcnt_d  = {RW{1'b0}};
      rep_d   = 1'b1;
    end else begin
      case (state_q)
        REP_IDLE: begin
          rcnt_d = {RW{1'b0}};
        end
        REP_WAIT: begin
          if (!REP_ON) begin
            rcnt_d = {RW{1'b0}};
          end else if (rcnt_q == DLY_LAST) begin
            rep_d   = 1'b1;
            rcnt_d  = {RW{1'b0}};
            state_d = REP_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RCNT_ONE;
          end
        end
        REP_REPEAT: begin
          if (rcnt_q == PER_LAST) begin
            rep_d  = 1'b1;
            rcnt_d = {RW{1'b0}};
          end else begin
            rcnt_d = rcnt_q + RCNT_ONE;
          end
        end
        default: begin
          state_d = REP_IDLE;
          rcnt_d  = {RW{1'b0}};
        end
      endcase
    end
  end

  // Synchroniser, counters, FSM state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
      state_q <= REP_IDLE;
      rcnt_q  <= {RW{1'b0}};
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign db    = db_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign rep   = rep_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Board push-button conditioner feeding the game's left/right controls
//   (bit positions KEY_LEFT / KEY_RIGHT). Applies key polarity and runs
//   one independent key_channel per line.
//   Ports:
//     clk          in   board clock
//     reset        in   asynchronous active-high reset
//     keys         in   raw button lines, asynchronous to clk
//     keys_db      out  debounced level, 1 = pressed
//     keys_press   out  one-cycle strobe on debounced 0->1
//     keys_release out  one-cycle strobe on debounced 1->0
//     keys_rep     out  one-cycle strobe on press and each auto-repeat
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NKEYS      = 4,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter bit INVERT     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys,
  output logic [NKEYS-1:0] keys_db,
  output logic [NKEYS-1:0] keys_press,
  output logic [NKEYS-1:0] keys_release,
  output logic [NKEYS-1:0] keys_rep
);

  logic [NKEYS-1:0] raw_s;

  // Active-low boards are flipped before synchronisation.
  assign raw_s = keys ^ {NKEYS{INVERT}};

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_channel #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_channel (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_s[i]),
      .db   (keys_db[i]),
      .press(keys_press[i]),
      .rel  (keys_release[i]),
      .rep  (keys_rep[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int RD   = 8;
  localparam int RP   = 3;
  localparam int HMAX = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] keys, keys_inv;
  logic [NK-1:0] keys_db, keys_press, keys_release, keys_rep;
  logic [NK-1:0] inv_db, inv_press, inv_release, inv_rep;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(NK), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP), .INVERT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .keys_db(keys_db), .keys_press(keys_press),
    .keys_release(keys_release), .keys_rep(keys_rep)
  );

  key_conditioner #(
    .NKEYS(NK), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP), .INVERT(1'b1)
  ) dut_inv (
    .clk(clk), .reset(reset), .keys(keys_inv),
    .keys_db(inv_db), .keys_press(inv_press),
    .keys_release(inv_release), .keys_rep(inv_rep)
  );

  // ---------------------------------------------------------------------
  // Reference model. Keeps the raw sample history since reset; the
  // synchronised value seen at edge n is the raw sample of edge n-2. The
  // level flips when the last DB synchronised samples (all after the
  // previous flip) differ from it. Repeat strobes come from the press
  // time by arithmetic: P, P+RD, P+RD+k*RP.
  // ---------------------------------------------------------------------
  logic [NK-1:0] exp_db, exp_press, exp_rel, exp_rep;
  int            edge_n;
  int            last_flip [NK];
  int            ptime     [NK];
  bit            held      [NK];
  bit            rawh      [NK][HMAX];
  bit            s2h       [NK][HMAX];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_n    <= 0;
      exp_db    <= '0;
      exp_press <= '0;
      exp_rel   <= '0;
      exp_rep   <= '0;
      for (int i = 0; i < NK; i++) begin
        last_flip[i] <= -1;
        ptime[i]     <= 0;
        held[i]      <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NK; i++) begin
        bit s2_now;
        bit flip;
        s2_now = (edge_n >= 2) ? rawh[i][(edge_n - 2) % HMAX] : 1'b0;
        flip   = ((edge_n - last_flip[i]) >= DB) && (s2_now != exp_db[i]);
        for (int j = edge_n - DB + 1; j < edge_n; j++)
          if (j >= 0 && s2h[i][j % HMAX] == exp_db[i]) flip = 1'b0;
        exp_press[i] <= flip && s2_now;
        exp_rel[i]   <= flip && !s2_now;
        if (flip) begin
          exp_db[i]    <= s2_now;
          last_flip[i] <= edge_n;
        end
        if (flip && s2_now) begin
          held[i]    <= 1'b1;
          ptime[i]   <= edge_n;
          exp_rep[i] <= 1'b1;
        end else if (flip) begin
          held[i]    <= 1'b0;
          exp_rep[i] <= 1'b0;
        end else begin
          exp_rep[i] <= held[i] && (RD > 0) && (edge_n >= ptime[i] + RD) &&
                        (((edge_n - ptime[i] - RD) % RP) == 0);
        end
        rawh[i][edge_n % HMAX] <= keys[i];
        s2h[i][edge_n % HMAX]  <= s2_now;
      end
      edge_n <= edge_n + 1;
    end
  end

  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    keys     = '0;
    keys_inv = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h0000) begin
        fails++;
        $display("FAIL reset_plain c=%0d got %h want 0000", c,
                 {keys_db, keys_press, keys_release, keys_rep});
      end
      tests++;
      if ({inv_db, inv_press, inv_release, inv_rep} !== 16'h0000) begin
        fails++;
        $display("FAIL reset_invert c=%0d got %h want 0000", c,
                 {inv_db, inv_press, inv_release, inv_rep});
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h0000) begin
        fails++;
        $display("FAIL idle_plain c=%0d got %h want 0000", c,
                 {keys_db, keys_press, keys_release, keys_rep});
      end
      tests++;
      if ({inv_db, inv_press, inv_release, inv_rep} !== 16'h0000) begin
        fails++;
        $display("FAIL idle_invert c=%0d got %h want 0000", c,
                 {inv_db, inv_press, inv_release, inv_rep});
      end
    end
  endtask

  task automatic test_single_press();
    @(negedge clk);
    keys[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (keys_press !== 4'b0000 || keys_db !== 4'b0000) begin
        fails++;
        $display("FAIL press_early c=%0d got db=%b press=%b want 0000/0000",
                 c, keys_db, keys_press);
      end
    end
    @(negedge clk);
    tests++;
    if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h1101) begin
      fails++;
      $display("FAIL press_edge got db=%b pr=%b rl=%b rp=%b want 0001/0001/0000/0001",
               keys_db, keys_press, keys_release, keys_rep);
    end
    @(negedge clk);
    tests++;
    if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h1000) begin
      fails++;
      $display("FAIL press_one_cycle got db=%b pr=%b rl=%b rp=%b want 0001/0000/0000/0000",
               keys_db, keys_press, keys_release, keys_rep);
    end
    keys[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_single c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 6; c++) begin
        keys[1] = (c < 3);
        @(negedge clk);
        tests++;
        if ({keys_db[1], keys_press[1], keys_release[1], keys_rep[1]} !== 4'b0000) begin
          fails++;
          $display("FAIL bounce r=%0d c=%0d got %b want 0000", r, c,
                   {keys_db[1], keys_press[1], keys_release[1], keys_rep[1]});
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_bounce c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
    end
  endtask

  task automatic test_repeat();
    bit found = 1'b0;
    @(negedge clk);
    keys[0] = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (keys_press[0]) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL repeat_press_timeout got no press want press within 20 cycles");
    end
    tests++;
    if (keys_rep[0] !== 1'b1) begin
      fails++;
      $display("FAIL repeat_on_press got %b want 1", keys_rep[0]);
    end
    for (int c = 1; c <= 30; c++) begin
      bit want;
      @(negedge clk);
      want = (c >= RD) && (((c - RD) % RP) == 0);
      tests++;
      if (keys_rep[0] !== want) begin
        fails++;
        $display("FAIL repeat_timing off=%0d got %b want %b", c, keys_rep[0], want);
      end
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_repeat c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
    end
    keys[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests++;
      if (keys_release[0] !== (c == 6)) begin
        fails++;
        $display("FAIL release_timing edge=%0d got %b want %b", c, keys_release[0], (c == 6));
      end
      tests++;
      if (keys_rep !== exp_rep) begin
        fails++;
        $display("FAIL model_rep_release edge=%0d got %b want %b", c, keys_rep, exp_rep);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (keys_rep[0] !== 1'b0 || keys_db[0] !== 1'b0) begin
        fails++;
        $display("FAIL after_release c=%0d got rep=%b db=%b want 0/0", c, keys_rep[0], keys_db[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit found = 1'b0;
    @(negedge clk);
    keys[1:0] = 2'b11;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (keys_press[0] || keys_press[1]) found = 1'b1;
    end
    tests++;
    if (keys_press[1:0] !== 2'b11) begin
      fails++;
      $display("FAIL simul_press got %b want 11", keys_press[1:0]);
    end
    for (int c = 1; c <= 25; c++) begin
      bit want;
      @(negedge clk);
      want = (c >= RD) && (((c - RD) % RP) == 0);
      tests++;
      if (keys_rep[0] !== want) begin
        fails++;
        $display("FAIL simul_rep0 off=%0d got %b want %b", c, keys_rep[0], want);
      end
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_simul c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
      if (c == 4) keys[1] = 1'b0;
    end
    keys = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int hold [NK];
    for (int i = 0; i < NK; i++) hold[i] = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NK; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          keys[i] = $urandom_range(0, 1);
          hold[i] = $urandom_range(1, 12);
        end
      end
      @(negedge clk);
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_random c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
      tests++;
      if ((keys_press & keys_release) !== 4'b0000) begin
        fails++;
        $display("FAIL press_release_overlap c=%0d got %b want 0000", c, keys_press & keys_release);
      end
    end
  endtask

  task automatic test_async_reset();
    keys = '0;
    repeat (12) @(negedge clk);
    keys = 4'b0001;
    repeat (20) @(negedge clk);
    tests++;
    if (keys_db !== 4'b0001) begin
      fails++;
      $display("FAIL held_before_reset got db=%b want 0001", keys_db);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h0000) begin
      fails++;
      $display("FAIL async_reset got %h want 0000", {keys_db, keys_press, keys_release, keys_rep});
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({keys_db, keys_press, keys_release, keys_rep} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_held got %h want 0000", {keys_db, keys_press, keys_release, keys_rep});
    end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests++;
      if (keys_press[0] !== (c == 6)) begin
        fails++;
        $display("FAIL repress_timing edge=%0d got %b want %b", c, keys_press[0], (c == 6));
      end
      tests++;
      if ({keys_db, keys_press, keys_release, keys_rep} !== {exp_db, exp_press, exp_rel, exp_rep}) begin
        fails++;
        $display("FAIL model_repress c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                 keys_db, keys_press, keys_release, keys_rep, exp_db, exp_press, exp_rel, exp_rep);
      end
    end
    keys = '0;
    repeat (10) @(negedge clk);
    tests++;
    if ({inv_db, inv_press, inv_release, inv_rep} !== 16'h0000) begin
      fails++;
      $display("FAIL invert_idle_end got %h want 0000", {inv_db, inv_press, inv_release, inv_rep});
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-conditioning stage directly upstream of the game top; feeds its left/right controls.
- Takes raw asynchronous push-button lines from the board.
- Synchronises each key, debounces it with a per-key stability counter, and produces a clean level, press/release strobes and an auto-repeat strobe.
- Runs on the undivided board clock, so strobes are one fast-clock cycle wide.

Parameters:
- NKEYS, 4, number of key lines.
- DB_CYCLES, 500000, consecutive cycles a synchronised input must differ from the debounced level before the level flips (10 ms at 50 MHz); must be ≥1.
- REP_DELAY, 12500000, cycles from press strobe to first auto-repeat strobe; 0 disables auto-repeat.
- REP_PERIOD, 5000000, cycles between subsequent auto-repeat strobes; must be ≥1.
- INVERT, 0, 1 = keys are active-low, inverted before synchronisation.

Ports:
- clk  input  1  board clock.
- reset  input  1  asynchronous, active-high reset.
- keys  input  NKEYS  raw button lines, asynchronous to clk.
- keys_db  output  NKEYS  debounced level, 1 = pressed.
- keys_press  output  NKEYS  one-cycle strobe on debounced 0→1.
- keys_release  output  NKEYS  one-cycle strobe on debounced 1→0.
- keys_rep  output  NKEYS  one-cycle strobe on press and on each auto-repeat.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All flops clear immediately: sync stages, counters, states, and all outputs = 0. Outputs are registered.
- Polarity: raw = keys XOR {NKEYS{INVERT}}.
- Synchroniser: 2-FF per bit (s1, s2); s2 is the only value used downstream.
- Debounce, per key i, counter cnt width clog2(DB_CYCLES+1):
  - If s2[i] == keys_db[i]: cnt ← 0.
  - Else if cnt == DB_CYCLES-1: keys_db[i] ← s2[i], cnt ← 0, and keys_press[i] or keys_release[i] ← 1 for that one cycle.
  - Else: cnt ← cnt+1.
  - Any sample matching keys_db restarts the count, so a bounce shorter than DB_CYCLES is fully rejected.
- Latency: a clean raw edge sampled at clock edge k appears on keys_db and its strobe after edge k+1+DB_CYCLES, i.e. DB_CYCLES+2 edges.
- Repeat FSM, per key; states IDLE, WAIT, REPEAT; counter rcnt sized for max(REP_DELAY, REP_PERIOD):
  - IDLE: on the press event → WAIT, rcnt ← 0, keys_rep ← 1 in the same cycle as keys_press.
  - WAIT: rcnt++. When rcnt == REP_DELAY-1: keys_rep ← 1, rcnt ← 0, → REPEAT.
  - REPEAT: rcnt++. When rcnt == REP_PERIOD-1: keys_rep ← 1, rcnt ← 0.
  - Release event in any state → IDLE, rcnt ← 0, no keys_rep on the release cycle.
  - REP_DELAY == 0: FSM stays in IDLE/WAIT with no repeat strobes; keys_rep equals keys_press.
  - Strobe timing: press at cycle P, repeats at P+REP_DELAY, then P+REP_DELAY+n·REP_PERIOD.
- Keys are fully independent. Simultaneous events on several keys strobe in the same cycle.
- keys_press and keys_release for one key are never both 1 in the same cycle.
- Reset mid-operation: all state is lost. A key still held when reset deasserts re-debounces from keys_db = 0 and yields a fresh press after DB_CYCLES+2 edges.
- Counter widths are unsigned with no wrap. Each counter saturates by construction at its terminal value.

Decomposition:
- Shared constants include for the default timing values (10 ms, 250 ms, 100 ms at 50 MHz) and for the key index assignments LEFT = 0, RIGHT = 1. The wrapper uses these for its keys→left/right mapping.
- Sub-module key_channel, one instance per key via generate. It holds the synchroniser, debounce counter and repeat FSM, with ports clk, reset, raw, db, press, release, rep.
- key_conditioner only handles polarity, the generate loop and bus packing.

Test Plan (bench params DB_CYCLES=4, REP_DELAY=8, REP_PERIOD=3, NKEYS=4):
- Reset with keys=4'b0000 held 20 cycles → all outputs 0 throughout. Repeat with INVERT=1 and keys=4'b1111 → still all 0.
- keys[0] 0→1 before edge k, held → keys_db[0] rises and keys_press[0] = keys_rep[0] = 1 for exactly one cycle after edge k+5. Other bits stay 0.
- keys[1] high 3 cycles then low, repeated twice (bounce) → keys_db, press, release and rep all stay 0.
- Hold keys[0] 30 cycles after press strobe at P → keys_rep[0] pulses at P, P+8, P+11, P+14, …. Drop keys[0] → keys_release[0] one cycle after 6 edges, with no further keys_rep.
- keys[0] and keys[1] rise the same cycle → both press strobes in the same cycle. Releasing keys[1] alone leaves keys[0] repeat timing unchanged.
- Assert reset while keys[0] held in REPEAT → outputs go to 0 asynchronously, before the next clk edge. Deassert with key still held → fresh press strobe 6 edges later.
